// File: rtl/tetris_input_pkg.sv
// Shared scan-code constants, command encoding and key-state bundle for the
// Tetris input path.
package tetris_input_pkg;

  localparam logic [7:0] KEY_LEFT     = 8'h6B;
  localparam logic [7:0] KEY_RIGHT    = 8'h74;
  localparam logic [7:0] KEY_ROTATE   = 8'h12;
  localparam logic [7:0] KEY_L_ROTATE = 8'h1A;
  localparam logic [7:0] KEY_R_ROTATE = 8'h22;
  localparam logic [7:0] KEY_ENTER    = 8'h5A;
  localparam logic [7:0] KEY_DOWN     = 8'h72;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROT_CW    = 3'd3,
    CMD_ROT_CCW   = 3'd4,
    CMD_SOFT_DROP = 3'd5,
    CMD_START     = 3'd6
  } cmd_code_e;

  typedef struct packed {
    logic       key1_on;
    logic [7:0] key1_code;
    logic       key2_on;
    logic [7:0] key2_code;
    logic       key3_on;
    logic [7:0] key3_code;
  } key_state_t;

  function automatic logic is_rotate_code(input logic [7:0] code);
    return (code == KEY_ROTATE) || (code == KEY_R_ROTATE) || (code == KEY_L_ROTATE);
  endfunction

endpackage

// File: rtl/auto_repeat_timer.sv
// Held-key repeat generator: one request on press/restart, one after FIRST_MS
// ticks, then one every REPEAT_MS ticks until release.
module auto_repeat_timer #(
  parameter int FIRST_MS  = 170,
  parameter int REPEAT_MS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic held,
  input  logic restart,
  input  logic tick,
  output logic req
);

  localparam int MAX_MS = (FIRST_MS > REPEAT_MS) ? FIRST_MS : REPEAT_MS;
  localparam int CW     = $clog2(MAX_MS + 1);

  typedef enum logic [1:0] {ART_IDLE, ART_FIRST, ART_REPEAT} art_state_e;

  art_state_e    state;
  logic [CW-1:0] ms_cnt;
  logic [CW-1:0] limit;
  logic [CW-1:0] cnt_inc;
  logic          hit;

  assign limit   = (state == ART_FIRST) ? CW'(FIRST_MS) : CW'(REPEAT_MS);
  assign cnt_inc = ms_cnt + CW'(1);
  assign hit     = tick && (cnt_inc == limit);

  // Request is decoded from current state so the caller's pending bit sets on
  // the edge right after the key becomes visible.
  assign req = held && ((state == ART_IDLE) || restart || hit);

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ART_IDLE;
      ms_cnt <= '0;
    end else if (!held) begin
      state  <= ART_IDLE;
      ms_cnt <= '0;
    end else if ((state == ART_IDLE) || restart) begin
      state  <= ART_FIRST;
      ms_cnt <= '0;
    end else if (tick) begin
      if (hit) begin
        state  <= ART_REPEAT;
        ms_cnt <= '0;
      end else begin
        ms_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns synchronized held-key state into a single valid/ready stream of game
// commands with DAS/ARR shifting, repeating soft drop and one-shot keys.
module key_cmd_scheduler
  import tetris_input_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DAS_MS   = 170,
  parameter int ARR_MS   = 50,
  parameter int SOFT_MS  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_on,
  input  logic [7:0] key1_code,
  input  logic       key2_on,
  input  logic [7:0] key2_code,
  input  logic       key3_on,
  input  logic [7:0] key3_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  key_state_t key_raw, key_meta, key_sync;

  assign key_raw = {key1_on, key1_code, key2_on, key2_code, key3_on, key3_code};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key_raw;
      key_sync <= key_meta;
    end
  end

  // Unrecognised codes decode as released.
  logic shift_held, shift_right, enter_pressed, rot_pressed, rot_ccw, drop_pressed;

  assign shift_held    = key_sync.key1_on &&
                         ((key_sync.key1_code == KEY_LEFT) || (key_sync.key1_code == KEY_RIGHT));
  assign shift_right   = key_sync.key1_on && (key_sync.key1_code == KEY_RIGHT);
  assign enter_pressed = key_sync.key1_on && (key_sync.key1_code == KEY_ENTER);
  assign rot_pressed   = key_sync.key2_on && is_rotate_code(key_sync.key2_code);
  assign rot_ccw       = key_sync.key2_code == KEY_L_ROTATE;
  assign drop_pressed  = key_sync.key3_on && (key_sync.key3_code == KEY_DOWN);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else      presc <= tick ? '0 : presc + PW'(1);
  end

  logic shift_held_q, shift_right_q, enter_q, rot_q;
  logic shift_restart, shift_set, drop_set, rot_set, start_set;

  // A left/right swap while held behaves like a fresh press.
  assign shift_restart = shift_held && shift_held_q && (shift_right != shift_right_q);
  assign rot_set       = rot_pressed && !rot_q;
  assign start_set     = enter_pressed && !enter_q;

  auto_repeat_timer #(.FIRST_MS(DAS_MS), .REPEAT_MS(ARR_MS)) u_shift_timer (
    .clk     (clk),
    .rst     (rst),
    .held    (shift_held),
    .restart (shift_restart),
    .tick    (tick),
    .req     (shift_set)
  );

  auto_repeat_timer #(.FIRST_MS(SOFT_MS), .REPEAT_MS(SOFT_MS)) u_drop_timer (
    .clk     (clk),
    .rst     (rst),
    .held    (drop_pressed),
    .restart (1'b0),
    .tick    (tick),
    .req     (drop_set)
  );

  logic      pend_rot, pend_rot_ccw, pend_shift, pend_shift_right, pend_drop, pend_start;
  logic      cmd_valid_q;
  cmd_code_e cmd_q;
  logic      accept, rot_presented, shift_presented;
  logic      acc_rot, acc_shift, acc_drop, acc_start;

  assign rot_presented   = cmd_valid_q && ((cmd_q == CMD_ROT_CW) || (cmd_q == CMD_ROT_CCW));
  assign shift_presented = cmd_valid_q && ((cmd_q == CMD_LEFT) || (cmd_q == CMD_RIGHT));
  assign accept          = cmd_valid_q && cmd_ready;
  assign acc_rot         = accept && rot_presented;
  assign acc_shift       = accept && shift_presented;
  assign acc_drop        = accept && (cmd_q == CMD_SOFT_DROP);
  assign acc_start       = accept && (cmd_q == CMD_START);

  logic      next_valid;
  cmd_code_e next_cmd;

  // The class being accepted this cycle is masked so it is not re-presented
  // before its pending bit has cleared.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    next_valid = 1'b1;
    next_cmd   = CMD_NONE;
    if (pend_rot && !acc_rot)
      next_cmd = pend_rot_ccw ? CMD_ROT_CCW : CMD_ROT_CW;
    else if (pend_shift && !acc_shift)
      next_cmd = pend_shift_right ? CMD_RIGHT : CMD_LEFT;
    else if (pend_drop && !acc_drop)
      next_cmd = CMD_SOFT_DROP;
    else if (pend_start && !acc_start)
      next_cmd = CMD_START;
    else
      next_valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_held_q     <= 1'b0;
      shift_right_q    <= 1'b0;
      enter_q          <= 1'b0;
      rot_q            <= 1'b0;
      pend_rot         <= 1'b0;
      pend_rot_ccw     <= 1'b0;
      pend_shift       <= 1'b0;
      pend_shift_right <= 1'b0;
      pend_drop        <= 1'b0;
      pend_start       <= 1'b0;
      cmd_valid_q      <= 1'b0;
      cmd_q            <= CMD_NONE;
    end else begin
      shift_held_q  <= shift_held;
      shift_right_q <= shift_right;
      enter_q       <= enter_pressed;
      rot_q         <= rot_pressed;

      // A set in the same cycle as acceptance wins, yielding one more command.
      pend_rot   <= rot_set   || (pend_rot   && !acc_rot);
      pend_shift <= shift_set || (pend_shift && !acc_shift);
      pend_drop  <= drop_set  || (pend_drop  && !acc_drop);
      pend_start <= start_set || (pend_start && !acc_start);

      // Direction is frozen while its command is on the port.
      if (rot_set && !rot_presented)     pend_rot_ccw     <= rot_ccw;
      if (shift_set && !shift_presented) pend_shift_right <= shift_right;

      if (!cmd_valid_q || cmd_ready) begin
        cmd_valid_q <= next_valid;
        cmd_q       <= next_cmd;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler at a 4-cycle ms tick: latency, DAS/ARR,
// one-shot keys, priority, back-pressure, direction swap and async reset.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       key1_on, key2_on, key3_on;
  logic [7:0] key1_code, key2_code, key3_code;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_code[$];
  int acc_cyc[$];

  key_cmd_scheduler #(.TICK_DIV(4), .DAS_MS(5), .ARR_MS(2), .SOFT_MS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .key1_on   (key1_on),
    .key1_code (key1_code),
    .key2_on   (key2_on),
    .key2_code (key2_code),
    .key3_on   (key3_on),
    .key3_code (key3_code),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the falling edge sees the
  // values the next rising edge will use.
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      acc_code.push_back(int'(cmd_code));
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_code(input int code, input int base);
    int n = 0;
    for (int i = base; i < acc_code.size(); i++)
      if (acc_code[i] == code) n++;
    return n;
  endfunction

  function automatic int nth_cyc(input int code, input int n, input int base);
    int k = 0;
    for (int i = base; i < acc_code.size(); i++) begin
      if (acc_code[i] == code) begin
        if (k == n) return acc_cyc[i];
        k++;
      end
    end
    return -1000;
  endfunction

  initial begin
    int base, base2, n_left, t1, t2, t3, t4;
    logic stable;

    rst = 1'b0; cmd_ready = 1'b1;
    key1_on = 1'b0; key2_on = 1'b0; key3_on = 1'b0;
    key1_code = 8'h00; key2_code = 8'h00; key3_code = 8'h00;
    step(1);
    check("reset_port", {cmd_valid, cmd_code}, 4'b0000);
    step(2);
    rst = 1'b1;
    step(2);
    check("idle_after_reset", {cmd_valid, cmd_code}, 4'b0000);

    // Left held 20 ms: latency, DAS gap, ARR gaps, silence after release.
    base = acc_code.size();
    key1_code = 8'h6B; key1_on = 1'b1;
    step(3);
    check("left_latency_3", cmd_valid, 1'b0);
    step(1);
    check("left_latency_4", {cmd_valid, cmd_code}, 4'b1001);
    step(76);
    t1 = nth_cyc(1, 0, base); t2 = nth_cyc(1, 1, base);
    t3 = nth_cyc(1, 2, base); t4 = nth_cyc(1, 3, base);
    check_range("left_das_gap", t2 - t1, 17, 20);
    check("left_arr_gap1", t3 - t2, 8);
    check("left_arr_gap2", t4 - t3, 8);
    key1_on = 1'b0;
    step(6);
    n_left = count_code(1, base);
    step(40);
    check("left_release_quiet", count_code(1, base), n_left);

    // One-shot rotations.
    base = acc_code.size();
    key2_code = 8'h1A; key2_on = 1'b1;
    step(40);
    key2_on = 1'b0;
    step(10);
    check("rot_ccw_once", count_code(4, base), 1);
    check("rot_ccw_no_cw", count_code(3, base), 0);
    base = acc_code.size();
    key2_code = 8'h22; key2_on = 1'b1;
    step(40);
    key2_on = 1'b0;
    step(10);
    check("rot_cw_once", count_code(3, base), 1);

    // Rotate and left together: rotate wins, left follows.
    base = acc_code.size();
    key1_code = 8'h6B; key1_on = 1'b1;
    key2_code = 8'h12; key2_on = 1'b1;
    step(4);
    check("prio_rot_first", {cmd_valid, cmd_code}, 4'b1011);
    step(1);
    check("prio_left_next", {cmd_valid, cmd_code}, 4'b1001);
    key1_on = 1'b0; key2_on = 1'b0;
    step(30);
    check("prio_left_count", count_code(1, base), 1);

    // Back-pressure: command holds stable, repeats absorbed.
    cmd_ready = 1'b0;
    base = acc_code.size();
    key1_code = 8'h6B; key1_on = 1'b1;
    step(4);
    check("stall_present", {cmd_valid, cmd_code}, 4'b1001);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!(cmd_valid === 1'b1 && cmd_code === 3'd1)) stable = 1'b0;
    end
    check("stall_stable_100", stable, 1'b1);
    key1_on = 1'b0;
    step(6);
    check("stall_after_release", {cmd_valid, cmd_code}, 4'b1001);
    cmd_ready = 1'b1;
    step(40);
    check("stall_one_accept", count_code(1, base), 1);

    // Direction swap while held restarts DAS with an immediate RIGHT.
    base = acc_code.size();
    key1_code = 8'h6B; key1_on = 1'b1;
    step(10);
    base2 = acc_code.size();
    key1_code = 8'h74;
    step(4);
    check("swap_right_4", {cmd_valid, cmd_code}, 4'b1010);
    step(40);
    check_range("swap_das_gap", nth_cyc(2, 1, base2) - nth_cyc(2, 0, base2), 17, 20);
    check("swap_no_left", count_code(1, base2), 0);
    check("swap_left_before", count_code(1, base), 1);
    key1_on = 1'b0;
    step(10);

    // Soft drop repeats every 3 ms.
    base = acc_code.size();
    key3_code = 8'h72; key3_on = 1'b1;
    step(4);
    check("drop_latency", {cmd_valid, cmd_code}, 4'b1101);
    step(40);
    t1 = nth_cyc(5, 0, base); t2 = nth_cyc(5, 1, base); t3 = nth_cyc(5, 2, base);
    check_range("drop_first_gap", t2 - t1, 9, 12);
    check("drop_repeat_gap", t3 - t2, 12);
    key3_on = 1'b0;
    step(10);

    // Enter is one-shot.
    base = acc_code.size();
    key1_code = 8'h5A; key1_on = 1'b1;
    step(30);
    key1_on = 1'b0;
    step(10);
    check("start_once", count_code(6, base), 1);

    // Unrecognised codes behave as released.
    base = acc_code.size();
    key1_code = 8'h00; key1_on = 1'b1;
    key3_code = 8'h73; key3_on = 1'b1;
    step(20);
    check("bad_codes_quiet", acc_code.size() - base, 0);
    key1_on = 1'b0; key3_on = 1'b0;
    step(5);

    // Async reset mid-command, then a fresh soft-drop press.
    cmd_ready = 1'b0;
    key3_code = 8'h72; key3_on = 1'b1;
    step(6);
    check("rst_pre_valid", {cmd_valid, cmd_code}, 4'b1101);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_drop", {cmd_valid, cmd_code}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; cmd_ready = 1'b1;
    step(3);
    check("rst_refill_3", cmd_valid, 1'b0);
    step(1);
    check("rst_fresh_drop", {cmd_valid, cmd_code}, 4'b1101);
    key3_on = 1'b0;
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
